// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared widths, ALU op encoding and reset values for the CPU slice.
// Rev    : 1.0
// ============================================================================
package cpu_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0] RD_DATA_RST = '0;

  typedef enum logic [2:0] {
    ALU_AND   = 3'b000,
    ALU_ADD   = 3'b001,
    ALU_SUB   = 3'b010,
    ALU_XOR   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_NOTA  = 3'b101,
    ALU_PASSA = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_e;

endpackage
`default_nettype wire

// File: rtl/cpu_alu.sv
`default_nettype none
// ============================================================================
// Module : cpu_alu
// Brief  : Combinational 32-bit execute-stage ALU, wrap-around, no flags.
// Rev    : 1.0
// ============================================================================
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int WIDTH = cpu_pkg::DATA_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       sel_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (alu_op_e'(sel_i))
      ALU_AND:   y_o = a_i & b_i;
      ALU_ADD:   y_o = a_i + b_i;
      ALU_SUB:   y_o = a_i - b_i;
      ALU_XOR:   y_o = a_i ^ b_i;
      ALU_OR:    y_o = a_i | b_i;
      ALU_NOTA:  y_o = ~a_i;
      ALU_PASSA: y_o = a_i;
      ALU_PASSB: y_o = b_i;
      default:   y_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sync_ram_cache_alu.sv
`default_nettype none
// ============================================================================
// Module : sync_ram_cache_alu
// Brief  : Word RAM behind a direct-mapped write-through cache, plus the ALU.
// Rev    : 1.0
// ============================================================================
module sync_ram_cache_alu
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int RAM_AW     = 12,
  parameter int LINES      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  hit,
  input  logic [DATA_WIDTH-1:0] alu_a,
  input  logic [DATA_WIDTH-1:0] alu_b,
  input  logic [2:0]            alu_sel,
  output logic [DATA_WIDTH-1:0] alu_out
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = RAM_AW - IDX_W;

  logic [RAM_AW-1:0]     ram_addr;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  wr_en;
  logic                  rd_en;
  logic                  line_hit;
  logic                  fill;
  logic [DATA_WIDTH-1:0] fill_data;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  unused_upper_addr;

  logic [DATA_WIDTH-1:0] mem_q  [2**RAM_AW];
  logic [DATA_WIDTH-1:0] data_q [LINES];
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [LINES-1:0]      valid_q;

  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  hit_q, hit_d;
  logic                  rd_valid_q, rd_valid_d;

  // Upper address bits are deliberately ignored so the RAM aliases.
  assign unused_upper_addr = ^addr[ADDR_WIDTH-1:RAM_AW];

  assign ram_addr  = addr[RAM_AW-1:0];
  assign idx       = addr[IDX_W-1:0];
  assign tag       = addr[RAM_AW-1:IDX_W];
  assign wr_en     = cs & we;
  assign rd_en     = cs & ~we & oe;
  assign ram_rdata = mem_q[ram_addr];
  assign line_hit  = valid_q[idx] && (tag_q[idx] == tag);

  // A write always allocates; a read refills only on a miss.
  assign fill      = wr_en | (rd_en & ~line_hit);
  assign fill_data = wr_en ? wr_data : ram_rdata;

  // Storage arrays carry no reset; rst_n gating drops ops sampled in reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem_q[ram_addr] <= wr_data;
    end
    if (rst_n && fill) begin
      data_q[idx] <= fill_data;
      tag_q[idx]  <= tag;
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    hit_d      = hit_q;
    rd_valid_d = 1'b0;
    if (rd_en) begin
      rd_valid_d = 1'b1;
      hit_d      = line_hit;
      rd_data_d  = line_hit ? data_q[idx] : ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      rd_data_q  <= DATA_WIDTH'(RD_DATA_RST);
      hit_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      if (fill) begin
        valid_q[idx] <= 1'b1;
      end
      rd_data_q  <= rd_data_d;
      hit_q      <= hit_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign hit      = hit_q;
  assign rd_valid = rd_valid_q;

  cpu_alu #(
    .WIDTH (DATA_WIDTH)
  ) u_alu (
    .a_i   (alu_a),
    .b_i   (alu_b),
    .sel_i (alu_sel),
    .y_o   (alu_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_sync_ram_cache_alu.sv
`default_nettype none
// ============================================================================
// Module : tb_sync_ram_cache_alu
// Brief  : Directed + random self-checking bench against a cache/RAM/ALU model.
// Rev    : 1.0
// ============================================================================
module tb_sync_ram_cache_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs, we, oe;
  logic [27:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        hit;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_sel;
  logic [31:0] alu_out;

  int tests = 0;
  int fails = 0;

  // Reference model: flat word memory plus per-line valid/tag of the cache.
  logic [31:0] mdl_mem [int];
  bit          mdl_valid [16];
  int          mdl_tag   [16];
  logic [31:0] exp_rd;
  logic        exp_hit;

  always #5 clk = ~clk;

  sync_ram_cache_alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .we       (we),
    .oe       (oe),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .hit      (hit),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_out  (alu_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl_valid[i] = 1'b0;
    exp_rd  = 32'h0;
    exp_hit = 1'b0;
  endtask

  // One memory cycle: drive on negedge, sample 1ns after the rising edge.
  task automatic mem_op(input string tag, input logic c, input logic w, input logic o,
                        input logic [27:0] a, input logic [31:0] d);
    int   key;
    int   li;
    int   lt;
    logic exp_v;
    key = int'(a % 28'd4096);
    li  = key % 16;
    lt  = key / 16;
    @(negedge clk);
    cs = c; we = w; oe = o; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    exp_v = 1'b0;
    if (c && w) begin
      mdl_mem[key]  = d;
      mdl_valid[li] = 1'b1;
      mdl_tag[li]   = lt;
    end else if (c && o) begin
      exp_v         = 1'b1;
      exp_hit       = mdl_valid[li] && (mdl_tag[li] == lt);
      exp_rd        = mdl_mem.exists(key) ? mdl_mem[key] : 32'hxxxxxxxx;
      mdl_valid[li] = 1'b1;
      mdl_tag[li]   = lt;
    end
    check({tag, ".rd_data"}, rd_data, exp_rd);
    check({tag, ".hit"}, {31'b0, hit}, {31'b0, exp_hit});
    check({tag, ".rd_valid"}, {31'b0, rd_valid}, {31'b0, exp_v});
  endtask

  task automatic alu_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] s);
    logic [31:0] e;
    alu_a = a; alu_b = b; alu_sel = s;
    #1;
    case (s)
      3'd0: e = a & b;
      3'd1: e = a + b;
      3'd2: e = a - b;
      3'd3: e = a ^ b;
      3'd4: e = a | b;
      3'd5: e = ~a;
      3'd6: e = a;
      default: e = b;
    endcase
    check(tag, alu_out, e);
  endtask

  initial begin
    logic [27:0] ra;
    logic [31:0] held;
    int          k;
    rst_n = 1'b0; cs = 0; we = 0; oe = 0; addr = '0; wr_data = '0;
    alu_a = '0; alu_b = '0; alu_sel = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("reset.rd_data", rd_data, 32'h0);
    check("reset.hit", {31'b0, hit}, 32'h0);
    check("reset.rd_valid", {31'b0, rd_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Program load and read-back
    mem_op("load.w0", 1, 1, 0, 28'h100, 32'h1000011E);
    mem_op("load.w1", 1, 1, 0, 28'h102, 32'h00000120);
    mem_op("load.w2", 1, 1, 0, 28'h104, 32'h1800011C);
    mem_op("load.r0", 1, 0, 1, 28'h100, 32'h0);
    check("load.r0.const", rd_data, 32'h1000011E);
    mem_op("load.r1", 1, 0, 1, 28'h102, 32'h0);
    check("load.r1.const", rd_data, 32'h00000120);
    mem_op("load.r2", 1, 0, 1, 28'h104, 32'h0);
    check("load.r2.const", rd_data, 32'h1800011C);
    check("load.r2.hit", {31'b0, hit}, 32'h1);

    // Conflict eviction on index 0
    mem_op("evict.w", 1, 1, 0, 28'h110, 32'hB8000001);
    mem_op("evict.r", 1, 0, 1, 28'h100, 32'h0);
    check("evict.r.hit", {31'b0, hit}, 32'h0);
    check("evict.r.const", rd_data, 32'h1000011E);
    mem_op("evict.rr", 1, 0, 1, 28'h100, 32'h0);
    check("evict.rr.hit", {31'b0, hit}, 32'h1);

    // Reset clears cache and outputs, not RAM; writes during reset are dropped
    mem_op("rst.w", 1, 1, 0, 28'h11A, 32'h78000009);
    mem_op("rst.r", 1, 0, 1, 28'h11A, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst.async.rd_data", rd_data, 32'h0);
    check("rst.async.hit", {31'b0, hit}, 32'h0);
    check("rst.async.rd_valid", {31'b0, rd_valid}, 32'h0);
    @(negedge clk);
    cs = 1; we = 1; oe = 0; addr = 28'h11A; wr_data = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    check("rst.held.rd_data", rd_data, 32'h0);
    @(negedge clk);
    cs = 0; we = 0;
    rst_n = 1'b1;
    mem_op("rst.after", 1, 0, 1, 28'h11A, 32'h0);
    check("rst.after.const", rd_data, 32'h78000009);
    check("rst.after.hit", {31'b0, hit}, 32'h0);

    // Write priority over read, then idle hold
    held = rd_data;
    mem_op("prio.w", 1, 1, 1, 28'h114, 32'h28000400);
    check("prio.rd_valid", {31'b0, rd_valid}, 32'h0);
    check("prio.hold", rd_data, held);
    mem_op("idle", 0, 0, 1, 28'h100, 32'h0);
    check("idle.hold", rd_data, held);
    mem_op("prio.r", 1, 0, 1, 28'h114, 32'h0);
    check("prio.r.const", rd_data, 32'h28000400);

    // ALU directed
    alu_op("alu.add", 32'd5, 32'd7, 3'b001);
    check("alu.add.const", alu_out, 32'h0000000C);
    alu_op("alu.sub", 32'd0, 32'd1, 3'b010);
    check("alu.sub.const", alu_out, 32'hFFFFFFFF);
    alu_op("alu.and", 32'hF0F0, 32'h0FF0, 3'b000);
    check("alu.and.const", alu_out, 32'h000000F0);
    alu_op("alu.or", 32'hF0F0, 32'h0FF0, 3'b100);
    check("alu.or.const", alu_out, 32'h0000FFF0);
    alu_op("alu.nota", 32'h0, 32'h1234, 3'b101);
    check("alu.nota.const", alu_out, 32'hFFFFFFFF);

    // Address alias through ignored upper bits
    mem_op("alias.w", 1, 1, 0, 28'h0000100, 32'h5);
    mem_op("alias.r", 1, 0, 1, 28'h1000100, 32'h0);
    check("alias.const", rd_data, 32'h5);
    check("alias.hit", {31'b0, hit}, 32'h1);

    // Random memory traffic over two conflicting regions with aliased uppers
    for (int n = 0; n < 300; n++) begin
      ra = ($urandom & 28'hFFFF000) |
           (($urandom_range(0, 1) != 0) ? 28'h100 : 28'h900) |
           28'($urandom_range(0, 31));
      k = $urandom_range(0, 9);
      if (k < 4 || !mdl_mem.exists(int'(ra % 28'd4096)))
        mem_op("rnd.w", 1, 1, ($urandom_range(0, 1) != 0), ra, $urandom);
      else if (k < 8)
        mem_op("rnd.r", 1, 0, 1, ra, $urandom);
      else if (k == 8)
        mem_op("rnd.idle_cs", 0, $urandom_range(0, 1) != 0, 1, ra, $urandom);
      else
        mem_op("rnd.idle_oe", 1, 0, 0, ra, $urandom);
    end

    for (int n = 0; n < 100; n++) begin
      alu_op("rnd.alu", $urandom, $urandom, 3'($urandom_range(0, 7)));
    end

    @(negedge clk);
    cs = 0; we = 0; oe = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
